// File: rtl/video_packet_decoder_pkg.sv
// Shared encodings for the video packet decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package video_pkt_pkg;

  // One-hot parser states.
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_HEAD = 4'b0010,
    ST_DATA = 4'b0100,
    ST_SKIP = 4'b1000
  } state_e;

  localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;
  localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;

  // Control payload is width(4) + height(4) + interlace(1) nibbles.
  localparam logic [3:0] CTRL_NIBBLES   = 4'd9;

endpackage

// File: rtl/video_packet_decoder_st_reg_slice.sv
// One-entry registered Avalon-ST stage carrying data, sop and eop.
// Latency: 1 cycle, full throughput when the sink keeps ready high.
// Backpressure: ready upstream = empty or being drained; a held beat is never dropped.
module st_reg_slice #(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_valid_i,
  input  logic          in_sop_i,
  input  logic          in_eop_i,
  output logic          in_ready_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  output logic          out_sop_o,
  output logic          out_eop_o,
  input  logic          out_ready_i
);

  logic          vld_q;
  logic [DW-1:0] data_q;
  logic          sop_q;
  logic          eop_q;

  assign in_ready_o  = !vld_q || out_ready_i;
  assign out_valid_o = vld_q;
  assign out_data_o  = data_q;
  assign out_sop_o   = sop_q;
  assign out_eop_o   = eop_q;

  // Load a new beat whenever the register is free or being emptied this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
    end else if (in_ready_o) begin
      vld_q <= in_valid_i;
      if (in_valid_i) begin
        data_q <= in_data_i;
        sop_q  <= in_sop_i;
        eop_q  <= in_eop_i;
      end
    end
  end

endmodule

// File: rtl/video_packet_decoder.sv
// Avalon-ST video packet parser: decodes control packets, forwards video pixels, checks frame size.
// Latency: 1 cycle from accepted pixel to dout; status pulses 1 cycle after the deciding beat.
// Backpressure: din_ready follows the output register only while in video data; otherwise always ready.
module video_packet_decoder
  import video_pkt_pkg::*;
#(
  parameter int COLOR_BITS   = 8,
  parameter int COLOR_PLANES = 3,
  parameter int DATA_WIDTH   = COLOR_BITS * COLOR_PLANES,
  parameter int TRUNCATE     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  input  logic                  din_startofpacket,
  input  logic                  din_endofpacket,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  input  logic                  dout_ready,
  output logic [15:0]           im_width,
  output logic [15:0]           im_height,
  output logic [3:0]            im_interlaced,
  output logic                  ctrl_valid,
  output logic                  frame_done,
  output logic                  frame_short,
  output logic                  frame_long,
  output logic                  pkt_error
);

  state_e      state_q, state_d;
  logic [35:0] hdr_q, hdr_d;
  logic [3:0]  nib_cnt_q, nib_cnt_d;
  logic [31:0] pix_cnt_q, pix_cnt_d, pix_cnt_inc;
  logic [31:0] expected_q, expected_d;
  logic [15:0] width_q, width_d, height_q, height_d;
  logic [3:0]  il_q, il_d;
  logic        first_q, first_d;
  logic        long_pend_q, long_pend_d;
  logic        have_ctrl_q, have_ctrl_d;
  logic        ctrl_valid_q, ctrl_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        short_q, short_d;
  logic        long_q, long_d;
  logic        pkt_error_q, pkt_error_d;
  logic        pix_vld, pix_eop, pix_rdy, trunc, checks_on, beat_acc;
  logic [3:0]  pkt_type;

  assign din_ready     = (state_q == ST_DATA) ? pix_rdy : 1'b1;
  assign beat_acc      = din_valid && din_ready;
  assign pkt_type      = din_data[3:0];
  assign im_width      = width_q;
  assign im_height     = height_q;
  assign im_interlaced = il_q;
  assign ctrl_valid    = ctrl_valid_q;
  assign frame_done    = frame_done_q;
  assign frame_short   = short_q;
  assign frame_long    = long_q;
  assign pkt_error     = pkt_error_q;

  // Parser next-state, header accumulation, pixel counting and per-frame status.
  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    nib_cnt_d    = nib_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    expected_d   = expected_q;
    width_d      = width_q;
    height_d     = height_q;
    il_d         = il_q;
    first_d      = first_q;
    long_pend_d  = long_pend_q;
    have_ctrl_d  = have_ctrl_q;
    ctrl_valid_d = 1'b0;
    frame_done_d = 1'b0;
    short_d      = 1'b0;
    long_d       = 1'b0;
    pkt_error_d  = 1'b0;
    pix_vld      = 1'b0;
    pix_eop      = 1'b0;
    pix_cnt_inc  = pix_cnt_q + 32'd1;
    // Size checks only mean something once a non-empty frame size is known.
    checks_on    = have_ctrl_q && (expected_q != 32'd0);
    trunc        = (TRUNCATE != 0) && checks_on && (pix_cnt_inc == expected_q);

    if (beat_acc) begin
      if (din_startofpacket) begin
        // A sop always restarts parsing; an unfinished packet is abandoned without an eop.
        if (state_q != ST_IDLE) pkt_error_d = 1'b1;
        long_pend_d = 1'b0;
        state_d     = ST_IDLE;
        if (din_endofpacket) begin
          if (pkt_type == PKT_TYPE_VIDEO) begin
            frame_done_d = 1'b1;
            short_d      = checks_on;
          end else if (pkt_type == PKT_TYPE_CTRL) begin
            pkt_error_d = 1'b1;
          end
        end else if (pkt_type == PKT_TYPE_VIDEO) begin
          state_d   = ST_DATA;
          pix_cnt_d = '0;
          first_d   = 1'b1;
        end else if (pkt_type == PKT_TYPE_CTRL) begin
          state_d   = ST_HEAD;
          hdr_d     = '0;
          nib_cnt_d = '0;
        end else begin
          state_d = ST_SKIP;
        end
      end else begin
        case (state_q)
          ST_HEAD: begin
            for (int k = 0; k < COLOR_PLANES; k++) begin
              if (nib_cnt_d < CTRL_NIBBLES) begin
                hdr_d     = {hdr_d[31:0], din_data[k*COLOR_BITS +: 4]};
                nib_cnt_d = nib_cnt_d + 4'd1;
              end
            end
            if ((nib_cnt_q < CTRL_NIBBLES) && (nib_cnt_d == CTRL_NIBBLES)) begin
              width_d      = hdr_d[35:20];
              height_d     = hdr_d[19:4];
              il_d         = hdr_d[3:0];
              expected_d   = {16'd0, hdr_d[35:20]} * {16'd0, hdr_d[19:4]};
              have_ctrl_d  = 1'b1;
              ctrl_valid_d = 1'b1;
            end
            if (din_endofpacket) begin
              state_d = ST_IDLE;
              if (nib_cnt_d != CTRL_NIBBLES) pkt_error_d = 1'b1;
            end
          end
          ST_DATA: begin
            pix_vld   = 1'b1;
            pix_eop   = din_endofpacket || trunc;
            pix_cnt_d = pix_cnt_inc;
            first_d   = 1'b0;
            if (din_endofpacket) begin
              state_d      = ST_IDLE;
              frame_done_d = 1'b1;
              short_d      = checks_on && (pix_cnt_inc < expected_q);
              long_d       = checks_on && (pix_cnt_inc > expected_q);
            end else if (trunc) begin
              // Frame already closed downstream; drop the tail and report at its eop.
              state_d     = ST_SKIP;
              long_pend_d = 1'b1;
            end
          end
          ST_SKIP: begin
            if (din_endofpacket) begin
              state_d      = ST_IDLE;
              frame_done_d = long_pend_q;
              long_d       = long_pend_q;
              long_pend_d  = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Parser state, committed control values and registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hdr_q        <= '0;
      nib_cnt_q    <= '0;
      pix_cnt_q    <= '0;
      expected_q   <= '0;
      width_q      <= '0;
      height_q     <= '0;
      il_q         <= '0;
      first_q      <= 1'b0;
      long_pend_q  <= 1'b0;
      have_ctrl_q  <= 1'b0;
      ctrl_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      short_q      <= 1'b0;
      long_q       <= 1'b0;
      pkt_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      nib_cnt_q    <= nib_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      expected_q   <= expected_d;
      width_q      <= width_d;
      height_q     <= height_d;
      il_q         <= il_d;
      first_q      <= first_d;
      long_pend_q  <= long_pend_d;
      have_ctrl_q  <= have_ctrl_d;
      ctrl_valid_q <= ctrl_valid_d;
      frame_done_q <= frame_done_d;
      short_q      <= short_d;
      long_q       <= long_d;
      pkt_error_q  <= pkt_error_d;
    end
  end

  st_reg_slice #(.DW(DATA_WIDTH)) u_out (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (din_data),
    .in_valid_i  (pix_vld),
    .in_sop_i    (first_q),
    .in_eop_i    (pix_eop),
    .in_ready_o  (pix_rdy),
    .out_data_o  (dout_data),
    .out_valid_o (dout_valid),
    .out_sop_o   (dout_startofpacket),
    .out_eop_o   (dout_endofpacket),
    .out_ready_i (dout_ready)
  );

endmodule

// File: tb/tb_video_packet_decoder.sv
// Bench for video_packet_decoder: table of frame cases, corner sequences, randomized packets vs model.
module tb_video_packet_decoder;
  import video_pkt_pkg::*;

  localparam int CB = 8;
  localparam int CP = 3;
  localparam int DW = CB * CP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 3-plane instance
  logic [DW-1:0] din_data = '0;
  logic din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0, din_ready;
  logic [DW-1:0] dout_data;
  logic dout_valid, dout_sop, dout_eop;
  logic dout_ready = 1'b1;
  logic [15:0] im_width, im_height;
  logic [3:0] im_il;
  logic ctrl_valid, frame_done, frame_short, frame_long, pkt_error;

  // 1-plane instance
  logic [7:0] din1_data = '0;
  logic din1_valid = 1'b0, din1_sop = 1'b0, din1_eop = 1'b0, din1_ready;
  logic [7:0] dout1_data;
  logic dout1_valid, dout1_sop, dout1_eop;
  logic [15:0] im1_width, im1_height;
  logic [3:0] im1_il;
  logic ctrl1_valid, frame1_done, frame1_short, frame1_long, pkt1_error;

  video_packet_decoder #(.COLOR_BITS(CB), .COLOR_PLANES(CP), .TRUNCATE(1)) dut (
    .clk(clk), .rst(rst),
    .din_data(din_data), .din_valid(din_valid), .din_startofpacket(din_sop),
    .din_endofpacket(din_eop), .din_ready(din_ready),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_startofpacket(dout_sop),
    .dout_endofpacket(dout_eop), .dout_ready(dout_ready),
    .im_width(im_width), .im_height(im_height), .im_interlaced(im_il),
    .ctrl_valid(ctrl_valid), .frame_done(frame_done), .frame_short(frame_short),
    .frame_long(frame_long), .pkt_error(pkt_error));

  video_packet_decoder #(.COLOR_BITS(8), .COLOR_PLANES(1), .TRUNCATE(1)) dut1 (
    .clk(clk), .rst(rst),
    .din_data(din1_data), .din_valid(din1_valid), .din_startofpacket(din1_sop),
    .din_endofpacket(din1_eop), .din_ready(din1_ready),
    .dout_data(dout1_data), .dout_valid(dout1_valid), .dout_startofpacket(dout1_sop),
    .dout_endofpacket(dout1_eop), .dout_ready(1'b1),
    .im_width(im1_width), .im_height(im1_height), .im_interlaced(im1_il),
    .ctrl_valid(ctrl1_valid), .frame_done(frame1_done), .frame_short(frame1_short),
    .frame_long(frame1_long), .pkt_error(pkt1_error));

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
  } ob_t;

  typedef struct {
    int npix;
    int nbeats;
    bit es;
    bit el;
  } vec_t;

  int errors = 0;
  int checks = 0;
  ob_t out_q[$];
  logic [1:0] done_q[$];
  logic [DW-1:0] sent_q[$];
  int ctrl_cnt = 0, err_cnt = 0, ctrl1_cnt = 0, err1_cnt = 0;
  bit rdy_rand = 1'b1;
  bit gap_en = 1'b1;

  // Reference model state: last committed control packet.
  bit m_have = 1'b0;
  int m_exp = 0;
  logic [15:0] m_w = '0, m_h = '0;
  logic [3:0] m_il = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [31:0] r;
    r = $urandom;
    return r[DW-1:0];
  endfunction

  // Sink ready toggles randomly; held high while draining.
  initial forever begin
    @(posedge clk); #1;
    dout_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: record handshakes and pulses away from the clock edge.
  initial forever begin
    @(negedge clk);
    if (dout_valid && dout_ready) out_q.push_back({dout_data, dout_sop, dout_eop});
    if (frame_done) done_q.push_back({frame_short, frame_long});
    if (ctrl_valid) ctrl_cnt++;
    if (pkt_error) err_cnt++;
    if (ctrl1_valid) ctrl1_cnt++;
    if (pkt1_error) err1_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear();
    out_q.delete(); done_q.delete(); sent_q.delete();
    ctrl_cnt = 0; err_cnt = 0;
  endtask

  task automatic drain();
    rdy_rand = 1'b0;
    step(5);
    rdy_rand = 1'b1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e);
    int n;
    din_data = d; din_sop = s; din_eop = e; din_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!din_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) begin
      errors++; checks++;
      $display("FAIL din_ready_timeout: got 0, want 1");
    end
    @(posedge clk); #1;
    din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    if (gap_en) step($urandom_range(0, 2));
  endtask

  task automatic send_video(input int n);
    logic [DW-1:0] d;
    d = rnd(); d[3:0] = PKT_TYPE_VIDEO;
    send_beat(d, 1'b1, n == 0);
    for (int i = 0; i < n; i++) begin
      d = rnd();
      sent_q.push_back(d);
      send_beat(d, 1'b0, i == n - 1);
    end
  endtask

  task automatic send_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
    logic [35:0] hv;
    logic [DW-1:0] d;
    int nb, idx;
    hv = {w, h, il};
    nb = (9 + CP - 1) / CP;
    d = rnd(); d[3:0] = PKT_TYPE_CTRL;
    send_beat(d, 1'b1, 1'b0);
    for (int b = 0; b < nb; b++) begin
      d = rnd();
      for (int k = 0; k < CP; k++) begin
        idx = b * CP + k;
        if (idx < 9) d[k*CB +: 4] = hv[35 - 4*idx -: 4];
      end
      send_beat(d, 1'b0, b == nb - 1);
    end
  endtask

  task automatic check_frame(input int nb, input bit es, input bit el);
    chk("beat_count", out_q.size(), nb);
    for (int i = 0; i < out_q.size() && i < nb; i++)
      chk("beat", out_q[i], {sent_q[i], i == 0, i == nb - 1});
    chk("frame_done_count", done_q.size(), 1);
    if (done_q.size() > 0) begin
      chk("frame_short", done_q[0][1], es);
      chk("frame_long", done_q[0][0], el);
    end
    chk("pkt_error_count", err_cnt, 0);
  endtask

  task automatic do_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
    clear();
    send_ctrl(w, h, il);
    drain();
    m_have = 1'b1; m_w = w; m_h = h; m_il = il; m_exp = int'(w) * int'(h);
    chk("im_width", im_width, m_w);
    chk("im_height", im_height, m_h);
    chk("im_interlaced", im_il, m_il);
    chk("ctrl_valid_count", ctrl_cnt, 1);
    chk("ctrl_pkt_error", err_cnt, 0);
    chk("ctrl_no_output", out_q.size() + done_q.size(), 0);
  endtask

  task automatic do_video(input int n);
    bit on;
    int nb;
    clear();
    send_video(n);
    drain();
    on = m_have && (m_exp != 0);
    nb = (on && n > m_exp) ? m_exp : n;
    check_frame(nb, on && (n < m_exp), on && (n > m_exp));
  endtask

  task automatic do_user(input logic [3:0] t, input int nb);
    logic [DW-1:0] d;
    clear();
    d = rnd(); d[3:0] = t;
    send_beat(d, 1'b1, nb == 1);
    for (int i = 1; i < nb; i++) send_beat(rnd(), 1'b0, i == nb - 1);
    drain();
    chk("user_no_output", out_q.size(), 0);
    chk("user_no_done", done_q.size(), 0);
    chk("user_no_error", err_cnt, 0);
    chk("user_im_width", im_width, m_w);
  endtask

  task automatic send1(input logic [7:0] d, input logic s, input logic e);
    din1_data = d; din1_sop = s; din1_eop = e; din1_valid = 1'b1;
    @(posedge clk); #1;
    din1_valid = 1'b0; din1_sop = 1'b0; din1_eop = 1'b0;
  endtask

  vec_t vt[6];
  logic [35:0] hv1;
  logic [DW-1:0] dd;

  initial begin
    // Frame cases with width 4, height 2 committed (expected 8 pixels).
    vt[0] = '{8, 8, 1'b0, 1'b0};
    vt[1] = '{11, 8, 1'b0, 1'b1};
    vt[2] = '{6, 6, 1'b1, 1'b0};
    vt[3] = '{0, 0, 1'b1, 1'b0};
    vt[4] = '{9, 8, 1'b0, 1'b1};
    vt[5] = '{1, 1, 1'b1, 1'b0};

    rst = 1'b1;
    step(3);
    rst = 1'b0;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_pulses", {ctrl_valid, frame_done, frame_short, frame_long, pkt_error}, 0);
    chk("rst_im", {im_width, im_height, im_il}, 0);
    chk("rst_din_ready", din_ready, 1);

    do_ctrl(16'd4, 16'd2, 4'd0);

    for (int i = 0; i < 6; i++) begin
      clear();
      send_video(vt[i].npix);
      drain();
      check_frame(vt[i].nbeats, vt[i].es, vt[i].el);
    end

    do_user(4'h3, 5);
    do_video(8);

    // 1-plane instance: 9 header nibbles, one per beat.
    hv1 = {16'h0140, 16'h00F0, 4'h0};
    send1(8'h5F, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send1({4'hC, hv1[35 - 4*i -: 4]}, 1'b0, 1'b0);
    step(1);
    chk("p1_no_commit_yet", ctrl1_cnt, 0);
    chk("p1_width_before", im1_width, 0);
    send1({4'h3, hv1[3:0]}, 1'b0, 1'b1);
    step(1);
    chk("p1_commit", ctrl1_cnt, 1);
    chk("p1_width", im1_width, 16'h0140);
    chk("p1_height", im1_height, 16'h00F0);
    send1(8'h0F, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send1(8'h09, 1'b0, i == 4);
    step(1);
    chk("p1_short_ctrl_error", err1_cnt, 1);
    chk("p1_short_ctrl_no_commit", ctrl1_cnt, 1);
    chk("p1_short_ctrl_im", {im1_width, im1_height}, {16'h0140, 16'h00F0});

    // sop inside a video packet, then reset mid-packet.
    clear();
    dd = rnd(); dd[3:0] = PKT_TYPE_VIDEO;
    send_beat(dd, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(rnd(), 1'b0, 1'b0);
    dd = rnd(); dd[3:0] = PKT_TYPE_VIDEO;
    send_beat(dd, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) send_beat(rnd(), 1'b0, 1'b0);
    step(1);
    chk("resop_pkt_error", err_cnt, 1);
    chk("resop_no_done", done_q.size(), 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_dout_valid", dout_valid, 0);
    chk("midrst_im", {im_width, im_height, im_il}, 0);
    m_have = 1'b0; m_exp = 0; m_w = '0; m_h = '0; m_il = '0;
    clear();
    send_beat(rnd(), 1'b0, 1'b1);
    drain();
    chk("postrst_discard_out", out_q.size(), 0);
    chk("postrst_discard_done", done_q.size(), 0);
    do_video(5);

    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 5);
      if (r == 0)      do_ctrl(16'($urandom_range(0, 6)), 16'($urandom_range(1, 4)), 4'($urandom_range(0, 15)));
      else if (r == 1) do_user(4'($urandom_range(1, 14)), $urandom_range(1, 5));
      else             do_video($urandom_range(0, 20));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
